// File: rtl/rca_pkg.sv
// Shared types for the multi-precision add/sub sequencer: FSM states and op encoding.
package rca_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/rca_mp_sequencer_rca.sv
// N-bit ripple-carry adder; also exposes the carry into the MSB for overflow detection.
module rca_mp_sequencer_rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o,
    output logic         cmsb_o
);
    logic [N:0] c;

    assign c[0] = cin_i;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o = c[N];
    assign cmsb_o = c[N-1];
endmodule

// File: rtl/rca_mp_sequencer.sv
// Multi-precision add/sub: steps one N-bit RCA over WORDS words, LSW first, carry chained
// through a register; result presented on a valid/ready handshake.
module rca_mp_sequencer
    import rca_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_op,
    input  logic [N*WORDS-1:0] in_a,
    input  logic [N*WORDS-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] out_sum,
    output logic               out_carry,
    output logic               out_ovf,
    output logic               busy
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    state_e             state_q;
    logic [IDXW-1:0]    idx_q;
    logic               carry_q;
    logic [N*WORDS-1:0] a_q, b_q, sum_q;
    logic               out_carry_q, ovf_q, in_ready_q, out_valid_q, busy_q;

    logic [N-1:0] a_w, b_w, s_w;
    logic         cout_w, cmsb_w;

    assign a_w = a_q[idx_q*N +: N];
    assign b_w = b_q[idx_q*N +: N];

    rca_mp_sequencer_rca #(.N(N)) u_rca (
        .a_i    (a_w),
        .b_i    (b_w),
        .cin_i  (carry_q),
        .sum_o  (s_w),
        .cout_o (cout_w),
        .cmsb_o (cmsb_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            out_carry_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        // Subtract is a + ~b + 1: invert B here, seed the carry with the op bit.
                        a_q        <= in_a;
                        b_q        <= (in_op == OP_SUB) ? ~in_b : in_b;
                        carry_q    <= in_op;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q*N +: N] <= s_w;
                    carry_q             <= cout_w;
                    if (idx_q == LAST) begin
                        out_carry_q <= cout_w;
                        ovf_q       <= cmsb_w ^ cout_w;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_rca_mp_sequencer.sv
// Directed bench for rca_mp_sequencer (N=8, WORDS=4) with hand-computed expectations.
module tb_rca_mp_sequencer;
    localparam int N = 8;
    localparam int WORDS = 4;
    localparam int W = N * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_op = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;
    logic         busy;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    rca_mp_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Accept one op and wait (bounded) for out_valid; leaves the result pending in DONE.
    task automatic start_op(input string tag, input logic op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        chk({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_op = ~op; in_a = $urandom; in_b = $urandom;
        chk({tag, ".busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, WORDS);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] s, input logic c,
                             input logic o);
        chk({tag, ".sum"}, out_sum, s);
        chk({tag, ".carry"}, out_carry, c);
        chk({tag, ".ovf"}, out_ovf, o);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".vld_drop"}, out_valid, 0);
        chk({tag, ".rdy_back"}, in_ready, 1);
    endtask

    task automatic do_op(input string tag, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] s, input logic c,
                         input logic o);
        start_op(tag, op, a, b);
        check_res(tag, s, c, o);
        release_out(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        check_res("rst", 32'h0, 0, 0);

        do_op("add_ff", 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 0, 0);
        do_op("add_wrap", 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0);
        do_op("sub_borrow", 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0);
        do_op("sub_ovf", 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1);
        do_op("add_ovf", 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1);

        // Backpressure: result must hold while in_valid and operands churn.
        start_op("bp", 1'b0, 32'h00010000, 32'h0000FFFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid; in_op = $urandom; in_a = $urandom; in_b = $urandom;
            @(posedge clk); #1;
            chk("bp.out_valid", out_valid, 1);
            chk("bp.in_ready", in_ready, 0);
            chk("bp.busy", busy, 0);
            check_res("bp", 32'h0001FFFF, 0, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out("bp");
        do_op("b2b_neg", 1'b0, 32'hA0000000, 32'hA0000000, 32'h40000000, 1, 1);
        do_op("b2b_zero", 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0);

        // Reset mid-RUN at idx=2, with in_valid asserted alongside it.
        @(negedge clk);
        in_valid = 1'b1; in_op = 1'b0; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid.busy_pre", busy, 1);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("mid.out_valid", out_valid, 0);
        chk("mid.in_ready", in_ready, 1);
        chk("mid.busy", busy, 0);
        check_res("mid", 32'h0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("mid.no_valid", out_valid, 0);
        chk("mid.still_idle", busy, 0);

        do_op("post_rst", 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
